// File: rtl/bt656_pkg.sv
// Shared definitions for the BT.656 capture path: output byte orders, decoder
// FSM states, TRS byte constants and the XY protection-nibble function.
package bt656_pkg;

    localparam logic [1:0] ORD_UYVY = 2'd0;
    localparam logic [1:0] ORD_YVYU = 2'd1;
    localparam logic [1:0] ORD_YUYV = 2'd2;
    localparam logic [1:0] ORD_VYUY = 2'd3;

    localparam logic [7:0] TRS_FF = 8'hFF;
    localparam logic [7:0] TRS_00 = 8'h00;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        BLANK  = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    // Expected {P3, P2, P1, P0} for a given {F, V, H}
    function automatic logic [3:0] trs_prot(input logic f, input logic v, input logic h);
        return {v ^ h, f ^ h, f ^ v, f ^ v ^ h};
    endfunction

    // Index into the captured {U, Y0, V, Y1} group for output slot k
    function automatic logic [1:0] order_idx(input logic [1:0] ord, input logic [1:0] k);
        case (ord)
            ORD_UYVY: return k;
            ORD_YVYU: return k + 2'd1;
            ORD_YUYV: return k ^ 2'd1;
            default:  return (k == 2'd3) ? 2'd3 : 2'd2 - k;
        endcase
    endfunction

endpackage

// File: rtl/bt656_trs_decode.sv
// TRS prefix matcher (FF 00 00) and XY protection check. With BT656_TRS_ECC_EN
// defined, single-bit XY errors are corrected; otherwise any mismatch is rejected.
module bt656_trs_decode
    import bt656_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din,
    output logic       in_trs,
    output logic       trs_valid,
    output logic       f,
    output logic       v,
    output logic       h,
    output logic       err
);

    logic [1:0] pre;
    logic       xy;
    logic [3:0] syn;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                 pre <= 2'd0;
        else if (din == TRS_FF)                  pre <= 2'd1;
        else if (pre == 2'd1 && din == TRS_00)   pre <= 2'd2;
        else if (pre == 2'd2 && din == TRS_00)   pre <= 2'd3;
        else                                     pre <= 2'd0;
    end

    // Covers the FF byte itself so a partial pixel group is never extended by it
    assign in_trs = (pre != 2'd0) || (din == TRS_FF);
    assign xy     = (pre == 2'd3);
    assign syn    = din[3:0] ^ trs_prot(din[6], din[5], din[4]);

`ifdef BT656_TRS_ECC_EN
    always_comb begin
        f         = din[6];
        v         = din[5];
        h         = din[4];
        trs_valid = 1'b0;
        err       = 1'b0;
        if (xy) begin
            err       = (syn != 4'd0) || !din[7];
            trs_valid = 1'b1;
            if (!din[7]) begin
                trs_valid = (syn == 4'd0);
            end else begin
                // Syndrome of a flipped data bit is that bit's protection column
                case (syn)
                    4'b0000, 4'b1000, 4'b0100, 4'b0010, 4'b0001: ;
                    4'b0111: f = ~din[6];
                    4'b1011: v = ~din[5];
                    4'b1101: h = ~din[4];
                    default: trs_valid = 1'b0;
                endcase
            end
        end
    end
`else
    assign f         = din[6];
    assign v         = din[5];
    assign h         = din[4];
    assign trs_valid = xy && din[7] && (syn == 4'd0);
    assign err       = xy && !(din[7] && (syn == 4'd0));
`endif

endmodule

// File: rtl/bt656_crop_decoder.sv
// BT.656 decoder: TRS timing, window crop, YUV422 reorder, camera-style output.
// Optional XY single-bit correction is enabled by defining BT656_TRS_ECC_EN.
module bt656_crop_decoder
    import bt656_pkg::*;
#(
    parameter int         DATA_W  = 10,
    parameter logic [1:0] ORDER   = 2'd1,
    parameter int         CROP_X0 = 0,
    parameter int         CROP_W  = 360,
    parameter int         CROP_Y0 = 0,
    parameter int         CROP_H  = 288
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        din,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              href,
    output logic              vsync,
    output logic              field,
    output logic              sync_lock,
    output logic              trs_err
);

    logic trs_valid, trs_f, trs_v, trs_h, trs_bad, in_trs;

    bt656_trs_decode u_trs (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .in_trs    (in_trs),
        .trs_valid (trs_valid),
        .f         (trs_f),
        .v         (trs_v),
        .h         (trs_h),
        .err       (trs_bad)
    );

    state_t                  state;
    logic [8:0]              line_cnt, grp_cnt;
    logic [1:0]              byte_idx, emit_idx;
    logic                    emit_on, prev_v;
    logic [2:0][7:0]         hold;
    logic [3:0][DATA_W-1:0]  obuf;
    logic [3:0][7:0]         grp_in;
    logic [3:0][DATA_W-1:0]  grp_ord;
    logic                    xy_cyc, capture, line_keep, grp_keep;

    function automatic logic [DATA_W-1:0] pad(input logic [7:0] b);
        logic [DATA_W-1:0] r;
        r = '0;
        r[DATA_W-1 -: 8] = b;
        return r;
    endfunction

    assign xy_cyc    = trs_valid || trs_bad;
    assign capture   = (state == ACTIVE) && !in_trs;
    assign line_keep = ({2'b0, line_cnt} >= 11'(CROP_Y0)) && ({2'b0, line_cnt} < 11'(CROP_Y0 + CROP_H));
    assign grp_keep  = ({2'b0, grp_cnt} >= 11'(CROP_X0)) && ({2'b0, grp_cnt} < 11'(CROP_X0 + CROP_W));
    assign grp_in    = {din, hold};

    for (genvar k = 0; k < 4; k++) begin : g_ord
        assign grp_ord[k] = pad(grp_in[order_idx(ORDER, 2'(k))]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            href       <= 1'b0;
            vsync      <= 1'b0;
            field      <= 1'b0;
            sync_lock  <= 1'b0;
            trs_err    <= 1'b0;
            state      <= HUNT;
            line_cnt   <= '0;
            grp_cnt    <= '0;
            byte_idx   <= '0;
            emit_idx   <= '0;
            emit_on    <= 1'b0;
            prev_v     <= 1'b0;
            hold       <= '0;
            obuf       <= '0;
        end else begin
            trs_err    <= trs_bad;
            dout_valid <= emit_on;
            href       <= emit_on;
            dout       <= emit_on ? obuf[emit_idx] : '0;
            if (emit_on) begin
                emit_idx <= emit_idx + 2'd1;
                if (emit_idx == 2'd3) emit_on <= 1'b0;
            end

            if (din == TRS_FF) byte_idx <= '0;

            if (capture) begin
                if (byte_idx != 2'd3) hold[byte_idx] <= din;
                byte_idx <= byte_idx + 2'd1;
                if (byte_idx == 2'd3) begin
                    if (grp_cnt != 9'h1FF) grp_cnt <= grp_cnt + 9'd1;
                    // Loading on the last emitted slot keeps back-to-back groups gap-free
                    if (line_keep && grp_keep) begin
                        obuf     <= grp_ord;
                        emit_on  <= 1'b1;
                        emit_idx <= '0;
                    end
                end
            end

            if (xy_cyc) begin
                if (state == ACTIVE) state <= BLANK;
                if (trs_valid) begin
                    sync_lock <= 1'b1;
                    vsync     <= trs_v;
                    field     <= trs_f;
                    prev_v    <= trs_v;
                    if (prev_v && !trs_v)
                        line_cnt <= '0;
                    else if (state == ACTIVE && trs_h)
                        line_cnt <= line_cnt + 9'd1;
                    if (!trs_h) begin
                        grp_cnt  <= '0;
                        byte_idx <= '0;
                        state    <= trs_v ? BLANK : ACTIVE;
                    end else begin
                        state    <= BLANK;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_bt656_crop_decoder.sv
// Scoreboard bench: dut0 (DATA_W=10, YVYU, no crop) and dut1 (DATA_W=8, UYVY, cropped window).
module tb_bt656_crop_decoder;

    typedef struct {
        logic [9:0] data;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] din0 = 8'h10;
    logic [7:0] din1 = 8'h10;
    logic [9:0] o0_dout;
    logic [7:0] o1_dout;
    logic       o0_valid, o0_href, o0_vsync, o0_field, o0_lock, o0_err;
    logic       o1_valid, o1_href, o1_vsync, o1_field, o1_lock, o1_err;
    int         cyc = 0, last_cyc = 0, checks = 0, errors = 0;
    exp_t       q0[$], q1[$];
    exp_t       e0, e1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bt656_crop_decoder #(.DATA_W(10), .ORDER(2'd1)) dut0 (
        .clk(clk), .rst(rst), .din(din0), .dout(o0_dout), .dout_valid(o0_valid),
        .href(o0_href), .vsync(o0_vsync), .field(o0_field), .sync_lock(o0_lock), .trs_err(o0_err)
    );

    bt656_crop_decoder #(.DATA_W(8), .ORDER(2'd0), .CROP_X0(2), .CROP_W(3), .CROP_Y0(1), .CROP_H(2)) dut1 (
        .clk(clk), .rst(rst), .din(din1), .dout(o1_dout), .dout_valid(o1_valid),
        .href(o1_href), .vsync(o1_vsync), .field(o1_field), .sync_lock(o1_lock), .trs_err(o1_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic put(input bit sel, input logic [7:0] b);
        @(negedge clk);
        if (sel) din1 = b; else din0 = b;
        last_cyc = cyc;
    endtask

    task automatic fill(input bit sel, input int n);
        for (int i = 0; i < n; i++) put(sel, 8'h10);
    endtask

    task automatic trs(input bit sel, input logic [7:0] xy);
        put(sel, 8'hFF); put(sel, 8'h00); put(sel, 8'h00); put(sel, xy);
    endtask

    // dut0 emits YVYU, each byte MSB-aligned in 10 bits, starting 5 cycles after U
    task automatic push0(input logic [7:0] u, input logic [7:0] y0, input logic [7:0] v,
                         input logic [7:0] y1, input int c);
        q0.push_back('{{y0, 2'b00}, c + 5});
        q0.push_back('{{v,  2'b00}, c + 6});
        q0.push_back('{{y1, 2'b00}, c + 7});
        q0.push_back('{{u,  2'b00}, c + 8});
    endtask

    task automatic grp(input bit sel, input logic [7:0] u, input logic [7:0] y0,
                       input logic [7:0] v, input logic [7:0] y1, input bit keep);
        int c;
        put(sel, u);
        c = last_cyc;
        put(sel, y0); put(sel, v); put(sel, y1);
        if (keep) begin
            if (!sel) push0(u, y0, v, y1, c);
            else begin
                q1.push_back('{{2'b00, u},  c + 5});
                q1.push_back('{{2'b00, y0}, c + 6});
                q1.push_back('{{2'b00, v},  c + 7});
                q1.push_back('{{2'b00, y1}, c + 8});
            end
        end
    endtask

    always @(negedge clk) begin
        if (o0_valid) begin
            checks++;
            if (q0.size() == 0) begin
                errors++;
                $display("FAIL d0_unexpected: got %0h at cyc %0d expected no output", o0_dout, cyc);
            end else begin
                e0 = q0.pop_front();
                if (o0_dout !== e0.data || o0_href !== 1'b1 || cyc != e0.cyc) begin
                    errors++;
                    $display("FAIL d0_byte: got %0h href %0b cyc %0d expected %0h href 1 cyc %0d",
                             o0_dout, o0_href, cyc, e0.data, e0.cyc);
                end
            end
        end else if (o0_href) begin
            checks++; errors++;
            $display("FAIL d0_href: got 1 with dout_valid 0 expected 0");
        end
    end

    always @(negedge clk) begin
        if (o1_valid) begin
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL d1_unexpected: got %0h at cyc %0d expected no output", o1_dout, cyc);
            end else begin
                e1 = q1.pop_front();
                if ({2'b00, o1_dout} !== e1.data || o1_href !== 1'b1 || cyc != e1.cyc) begin
                    errors++;
                    $display("FAIL d1_byte: got %0h href %0b cyc %0d expected %0h href 1 cyc %0d",
                             o1_dout, o1_href, cyc, e1.data, e1.cyc);
                end
            end
        end else if (o1_href) begin
            checks++; errors++;
            $display("FAIL d1_href: got 1 with dout_valid 0 expected 0");
        end
    end

    initial begin
        logic [7:0] b;
        int c;
        repeat (3) @(negedge clk);
        chk("rst_dout0",  o0_dout, 0);
        chk("rst_valid0", o0_valid, 0);
        chk("rst_href0",  o0_href, 0);
        chk("rst_vsync0", o0_vsync, 0);
        chk("rst_field0", o0_field, 0);
        chk("rst_lock0",  o0_lock, 0);
        chk("rst_err0",   o0_err, 0);
        chk("rst_out1",   {o1_dout, o1_valid, o1_href, o1_vsync, o1_field, o1_lock, o1_err}, 0);
        rst = 1'b0;

        // Crop window on dut1: lines 1..2, groups 2..4 of 8
        fill(1, 4);
        trs(1, 8'hB6);
        trs(1, 8'hAB);
        fill(1, 4);
        for (int l = 0; l < 4; l++) begin
            trs(1, 8'h80);
            for (int g = 0; g < 8; g++) begin
                b = 8'(17 + l * 48 + g * 4);
                grp(1, b, b + 8'd1, b + 8'd2, b + 8'd3, (l >= 1 && l <= 2 && g >= 2 && g <= 4));
            end
            trs(1, 8'h9D);
            fill(1, 6);
        end
        chk("d1_lock", o1_lock, 1);
        chk("d1_vsync", o1_vsync, 0);
        chk("d0_hunt_lock", o0_lock, 0);

        // Field / vsync on dut0
        fill(0, 4);
        trs(0, 8'hB6);
        @(negedge clk);
        chk("vsync_b6", o0_vsync, 1);
        chk("field_b6", o0_field, 0);
        chk("lock_b6", o0_lock, 1);
        chk("err_b6", o0_err, 0);
        trs(0, 8'hF1);
        @(negedge clk);
        chk("field_f1", o0_field, 1);
        chk("vsync_f1", o0_vsync, 1);

        // Single-group valid line, YVYU order
        trs(0, 8'h80);
        grp(0, 8'h10, 8'h20, 8'h30, 8'h40, 1'b1);
        trs(0, 8'h9D);
        fill(0, 8);
        chk("vsync_line", o0_vsync, 0);
        chk("field_line", o0_field, 0);

        // Protection error: bad P0
        trs(0, 8'h81);
        put(0, 8'h11);
        c = last_cyc;
        chk("trs_err_pulse", o0_err, 1);
        put(0, 8'h22);
        chk("trs_err_clear", o0_err, 0);
        put(0, 8'h33);
        put(0, 8'h44);
`ifdef BT656_TRS_ECC_EN
        push0(8'h11, 8'h22, 8'h33, 8'h44, c);
`endif
        trs(0, 8'h9D);
        fill(0, 8);

        // Short line: 2.5 groups
        trs(0, 8'h80);
        grp(0, 8'h51, 8'h52, 8'h53, 8'h54, 1'b1);
        grp(0, 8'h61, 8'h62, 8'h63, 8'h64, 1'b1);
        put(0, 8'h71);
        put(0, 8'h72);
        trs(0, 8'h9D);
        fill(0, 8);

        // Mid-line reset on an F=1 line
        trs(0, 8'hC7);
        grp(0, 8'h31, 8'h32, 8'h33, 8'h34, 1'b1);
        grp(0, 8'h35, 8'h36, 8'h37, 8'h38, 1'b1);
        #2;
        chk("pre_rst_href", o0_href, 1);
        chk("pre_rst_field", o0_field, 1);
        rst = 1'b1;
        #1;
        q0.delete();
        chk("mid_rst_dout",  o0_dout, 0);
        chk("mid_rst_valid", o0_valid, 0);
        chk("mid_rst_href",  o0_href, 0);
        chk("mid_rst_field", o0_field, 0);
        chk("mid_rst_lock",  o0_lock, 0);
        @(negedge clk);
        rst = 1'b0;
        chk("post_rst_lock", o0_lock, 0);
        grp(0, 8'h41, 8'h42, 8'h43, 8'h44, 1'b0);
        fill(0, 6);
        chk("hunt_lock", o0_lock, 0);
        trs(0, 8'h80);
        grp(0, 8'h81, 8'h82, 8'h83, 8'h84, 1'b1);
        chk("relock", o0_lock, 1);
        trs(0, 8'h9D);
        fill(0, 4);

        for (int i = 0; i < 60 && (q0.size() != 0 || q1.size() != 0); i++) @(negedge clk);
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
